// File: rtl/uart_rx_cfg.sv
`default_nettype none
// =====================================================================
// uart_rx_cfg : configurable UART receiver with an error-flagged RX FIFO
// Revision    : 1.0
// =====================================================================
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frm_err,
  output logic                 par_err,
  output logic                 rdy,
  output logic                 ovr_err,
  output logic                 busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = DATA_BITS + 2;
  localparam int BIT_W = 4;
  localparam logic [DIV_W-1:0] DIV_ONE  = 1;
  localparam logic [BIT_W-1:0] BIT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic             ODD_BIT  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  logic                 rx_prev_q, rx_prev_d;
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frm_bad_q, frm_bad_d;
  logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovr_q, ovr_d;

  logic                 sample;
  logic                 fall;
  logic                 push;
  logic [ENT_W-1:0]     push_ent;
  logic                 rd_fire;
  logic                 wr_fire;
  logic                 full;
  logic [ENT_W-1:0]     head;

  // Receiver FSM: all timing derives from baud_cnt hitting zero.
  always_comb begin
    rx_meta_d  = RX;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    state_d    = state_q;
    div_d      = div_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    frm_bad_d  = frm_bad_q;
    push       = 1'b0;
    push_ent   = {par_bad_q, frm_bad_q | ~rx_sync_q, shift_q};
    fall       = ~rx_sync_q & rx_prev_q;
    sample     = (state_q != S_IDLE) && (baud_cnt_q == '0);

    if (state_q != S_IDLE) begin
      baud_cnt_d = sample ? (div_q - DIV_ONE) : (baud_cnt_q - DIV_ONE);
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          div_d      = baud_div;
          baud_cnt_d = (baud_div >> 1) - DIV_ONE;
          bit_cnt_d  = '0;
          par_bad_d  = 1'b0;
          frm_bad_d  = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (sample) begin
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_bad_d = (^shift_q) ^ rx_sync_q ^ ODD_BIT;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          if (!rx_sync_q) begin
            frm_bad_d = 1'b1;
          end
          if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: a pop in the same cycle frees the slot for a push into a full FIFO.
  always_comb begin
    rd_fire  = rd_en && (count_q != '0);
    full     = (count_q == CNT_FULL);
    wr_fire  = push && (!full || rd_fire);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) begin
      mem_d[wr_ptr_q] = push_ent;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_fire && !rd_fire) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_fire && rd_fire) begin
      count_d = count_q - CNT_ONE;
    end
    if (push && full && !rd_fire) begin
      ovr_d = 1'b1;
    end else if (clr_err) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      div_q      <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      frm_bad_q  <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      state_q    <= state_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      frm_bad_q  <= frm_bad_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign rdy     = (count_q != '0);
  assign rx_data = rdy ? head[DATA_BITS-1:0] : '0;
  assign frm_err = rdy & head[DATA_BITS];
  assign par_err = rdy & head[DATA_BITS+1];
  assign ovr_err = ovr_q;
  assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire
